// File: rtl/alu_sequencer.sv
// alu_sequencer: non-pipelined 4-register ALU sequencer.
// Each accepted instruction runs to completion before the next one is taken.
// An ALU instruction goes IDLE -> READ -> EXEC -> WB; a load goes IDLE -> WB.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   instr[9:0]         {mode, op[2:0], rd[1:0], rs[1:0], rt[1:0]}
//   instr_valid/ready  instruction handshake (ready only in IDLE)
//   res_data[3:0]      result, stable while res_valid is high
//   res_valid/ready    result handshake; completing it writes R[rd]
//   busy               high whenever not IDLE
//   done_cnt[CNT_W-1:0] completed-instruction count, wraps
module alu_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned DW = 4;
  localparam int unsigned NREG = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       rd_q, rd_d;
  logic [1:0]       rs_q, rs_d;
  logic [1:0]       rt_q, rt_d;
  logic [DW-1:0]    opa_q, opa_d;
  logic [DW-1:0]    opb_q, opb_d;
  logic [DW-1:0]    res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rf_q [NREG];
  logic [DW-1:0]    rf_d [NREG];
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    alu_c;

  // ALU on the latched operands
  always_comb begin
    alu_c = '0;
    case (op_q)
      3'd0:    alu_c = opa_q + opb_q;
      3'd1:    alu_c = opa_q - opb_q;
      3'd2:    alu_c = opa_q & opb_q;
      3'd3:    alu_c = opa_q | opb_q;
      3'd4:    alu_c = {opa_q[2:0], opa_q[3]};
      3'd5:    alu_c = {opb_q[3], opb_q[3:1]};
      3'd6:    alu_c = {3'b111, (opa_q == opb_q)};
      default: alu_c = {3'b101, (opa_q > opb_q)};
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d = instr[8:6];
          rd_d = instr[5:4];
          rs_d = instr[3:2];
          rt_d = instr[1:0];
          if (instr[9]) begin
            // load: immediate is the {rs, rt} field
            res_d   = instr[3:0];
            state_d = S_WB;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        opa_d   = rf_q[rs_q];
        opb_d   = rf_q[rt_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_c;
        state_d = S_WB;
      end
      default: begin
        if (res_ready) begin
          rf_d[rd_q] = res_q;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = S_IDLE;
        end
      end
    endcase
    // status outputs are registered copies of the next-state decode
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign res_valid   = valid_q;
  assign res_data    = res_q;
  assign done_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed scenarios plus random traffic,
// checked every cycle against an instruction-level model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       res_ready = 1'b0;

  logic       instr_ready, res_valid, busy;
  logic [3:0] res_data;
  logic [7:0] done_cnt;
  logic       instr_ready2, res_valid2, busy2;
  logic [3:0] res_data2;
  logic [1:0] done_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .done_cnt(done_cnt)
  );

  alu_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready2), .res_data(res_data2), .res_valid(res_valid2),
    .res_ready(res_ready), .busy(busy2), .done_cnt(done_cnt2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference ALU in plain arithmetic
  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a & b;
      3: return a | b;
      4: return ((a * 2) % 16) + (a / 8);
      5: return (b / 2) + ((b >= 8) ? 8 : 0);
      6: return 14 + ((a == b) ? 1 : 0);
      default: return 10 + ((a > b) ? 1 : 0);
    endcase
  endfunction

  // instruction-level model: one instruction in flight, result after a delay
  int m_regs [4];
  int m_busy, m_valid, m_data, m_cnt, m_wait, m_pend, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_data = 0; m_cnt = 0; m_wait = 0; m_pend = 0; m_rd = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
    end else if (m_busy == 0) begin
      if (instr_valid) begin
        m_busy = 1;
        m_rd = int'(instr[5:4]);
        if (instr[9]) begin
          m_valid = 1;
          m_data = int'(instr[3:0]);
        end else begin
          m_wait = 2;
          m_pend = ref_alu(int'(instr[8:6]), m_regs[instr[3:2]], m_regs[instr[1:0]]);
        end
      end
    end else if (m_valid == 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1;
        m_data = m_pend;
      end
    end else if (res_ready) begin
      m_regs[m_rd] = m_data;
      m_cnt++;
      m_valid = 0;
      m_busy = 0;
    end
  end

  // per-cycle comparison, on the falling edge
  always @(negedge clk) begin
    check("instr_ready", int'(instr_ready), (m_busy == 0) ? 1 : 0);
    check("busy", int'(busy), m_busy);
    check("res_valid", int'(res_valid), m_valid);
    check("res_data", int'(res_data), m_data);
    check("done_cnt", int'(done_cnt), m_cnt % 256);
    check("busy_w2", int'(busy2), m_busy);
    check("res_valid_w2", int'(res_valid2), m_valid);
    check("res_data_w2", int'(res_data2), m_data);
    check("ready_w2", int'(instr_ready2), (m_busy == 0) ? 1 : 0);
    check("done_cnt_w2", int'(done_cnt2), m_cnt % 4);
  end

  // issue one instruction, optionally stall the result, then complete it
  task automatic do_instr(input bit mode, input int op, input int rd, input int rs,
                          input int rt, input int hold, output int got, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!instr_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ready_timeout", 0, 1);
    instr = {mode, 3'(op), 2'(rd), 2'(rs), 2'(rt)};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    t = 0;
    while (!res_valid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("valid_timeout", 0, 1);
    lat = t;
    got = int'(res_data);
    for (int i = 0; i < hold; i++) begin
      instr = 10'($urandom);
      instr_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", int'(res_valid), 1);
      check("hold_data", int'(res_data), got);
      check("hold_ready", int'(instr_ready), 0);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(instr_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(res_valid), 0);
    check({tag, "_data"}, int'(res_data), 0);
    check({tag, "_cnt"}, int'(done_cnt), 0);
  endtask

  // asynchronous pulse placed between clock edges, spanning one rising edge
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  int got, lat;
  int wrap_exp [5];

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // reset clears results and registers
    do_instr(1'b1, 0, 1, 1, 1, 0, got, lat);
    check("pre_reset_load", got, 5);
    pulse_reset("rst");
    for (int r = 0; r < 4; r++) begin
      do_instr(1'b0, 3, r, r, r, 0, got, lat);
      check("reg_after_reset", got, 0);
    end
    pulse_reset("rst2");

    // load, add, subtract
    do_instr(1'b1, 0, 1, 1, 1, 0, got, lat);
    check("load_r1", got, 5);
    check("load_latency", lat, 0);
    do_instr(1'b1, 0, 2, 0, 3, 0, got, lat);
    check("load_r2", got, 3);
    do_instr(1'b0, 0, 3, 1, 2, 0, got, lat);
    check("add", got, 8);
    check("alu_latency", lat, 2);
    do_instr(1'b0, 1, 0, 2, 1, 0, got, lat);
    check("sub", got, 14);
    check("cnt_after_4", int'(done_cnt), 4);

    // compare, rotate, shift
    do_instr(1'b0, 6, 0, 1, 1, 0, got, lat);
    check("eq", got, 15);
    do_instr(1'b0, 7, 0, 2, 1, 0, got, lat);
    check("gt_false", got, 10);
    do_instr(1'b0, 7, 0, 1, 2, 0, got, lat);
    check("gt_true", got, 11);
    do_instr(1'b1, 0, 1, 2, 1, 0, got, lat);
    do_instr(1'b0, 4, 0, 1, 0, 0, got, lat);
    check("rotl", got, 3);
    do_instr(1'b1, 0, 2, 2, 0, 0, got, lat);
    do_instr(1'b0, 5, 0, 0, 2, 0, got, lat);
    check("asr", got, 12);

    // backpressure: R1=9, R2=8, R3=8 before; result 1 lands only on handshake
    do_instr(1'b0, 0, 3, 1, 2, 5, got, lat);
    check("bp_result", got, 1);
    do_instr(1'b0, 3, 3, 3, 3, 0, got, lat);
    check("bp_r3", got, 1);

    // reset while the ADD to R3 is in EXEC
    @(negedge clk);
    instr = {1'b0, 3'd0, 2'd3, 2'd1, 2'd2};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("in_exec_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_exec");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // counter wrap on the 2-bit instance
    wrap_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      do_instr(1'b1, 0, 0, 0, i, 0, got, lat);
      check("wrap_cnt", int'(done_cnt2), wrap_exp[i]);
    end
    do_instr(1'b0, 3, 3, 3, 3, 0, got, lat);
    check("r3_after_exec_reset", got, 0);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      instr = 10'($urandom);
      instr_valid = ($urandom_range(0, 1) == 1);
      res_ready = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    res_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-instruction counter.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port instr  input  10  instruction word {mode, op[2:0], rd[1:0], rs[1:0], rt[1:0]}.
REQ-005 The block SHALL have port instr_valid  input  1  instruction offered.
REQ-006 The block SHALL have port instr_ready  output  1  instruction accepted when instr_valid and instr_ready are both high at a clk edge.
REQ-007 The block SHALL have port res_data  output  4  result of the current instruction.
REQ-008 The block SHALL have port res_valid  output  1  res_data is valid.
REQ-009 The block SHALL have port res_ready  input  1  downstream accepts the result.
REQ-010 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 The block SHALL have port done_cnt  output  CNT_W  count of completed instructions.

Function
REQ-012 The block SHALL hold four 4-bit registers R0-R3, addressed by rd, rs and rt.
REQ-013 The FSM SHALL have four states, IDLE, READ, EXEC and WB, with instr_ready=1 only in IDLE.
REQ-014 On acceptance with mode=0, the FSM SHALL go IDLE->READ; READ SHALL latch R[rs] and R[rt] into operand registers, then go to EXEC.
REQ-015 EXEC SHALL register the ALU result into res_data, then go to WB.
REQ-016 On acceptance with mode=1 (load), the block SHALL latch res_data={rs,rt} (a 4-bit immediate) and go IDLE->WB directly.
REQ-017 The ALU operation SHALL be selected by op, all results 4 bits:
  - 000: rs+rt mod 16
  - 001: rs-rt mod 16 (two's complement)
  - 010: rs AND rt
  - 011: rs OR rt
  - 100: rotate rs left by 1, {rs[2:0],rs[3]}
  - 101: arithmetic shift rt right by 1, {rt[3],rt[3:1]}
  - 110: {1,1,1,(rs==rt)}
  - 111: {1,0,1,(rs>rt unsigned)}
REQ-018 res_valid SHALL be high exactly while in WB, and res_data SHALL be stable throughout WB.
REQ-019 In WB with res_ready=1, the edge SHALL write R[rd]<=res_data, increment done_cnt, and return to IDLE.
REQ-020 In WB with res_ready=0, the block SHALL hold state, res_data and res_valid, and SHALL NOT write the register file.
REQ-021 Latency: an ALU instruction accepted at edge N SHALL raise res_valid after edge N+2; a load accepted at edge N SHALL raise res_valid after edge N.
REQ-022 The next instruction SHALL be accepted no earlier than the edge after the result handshake.
REQ-023 Because instructions do not overlap, operands SHALL always see the prior write (no hazard logic).
REQ-024 done_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 instr_valid in any state other than IDLE SHALL be ignored.
REQ-026 rd equal to rs or rt SHALL be legal, with the write occurring after the read.

Reset
REQ-027 When rst_n=0, the block SHALL immediately force state=IDLE, R0-R3=0, res_data=0, res_valid=0, done_cnt=0, instr_ready=1 and busy=0.
REQ-028 Reset asserted mid-instruction SHALL discard the instruction without a register write or count increment.
REQ-029 Operation SHALL resume on the first clk edge after rst_n rises.

Verification
REQ-030 Reset: pulse rst_n low asynchronously between edges -> outputs at reset values immediately; registers read back 0.
REQ-031 Load R1=5 and R2=3, then ADD rd=3 rs=1 rt=2 -> res_data=8 with res_valid after edge N+2; then SUB rd=0 rs=2 rt=1 -> 4'hE; done_cnt=4.
REQ-032 Compare and shift, with R1=5, R2=3:
  - op110 rs=1 rt=1 -> 4'hF
  - op111 rs=2 rt=1 -> 4'hA
  - op111 rs=1 rt=2 -> 4'hB
  - load R1=4'b1001, then op100 -> 4'b0011
  - load R2=4'b1000, then op101 rt=2 -> 4'b1100
REQ-033 Backpressure: hold res_ready=0 for 5 cycles in WB -> res_valid and res_data stable, instr_ready=0, instr_valid ignored, R[rd] unchanged until the handshake edge.
REQ-034 Reset in EXEC: assert rst_n low during an ADD to R3 -> R3=0, done_cnt=0, IDLE on release.
REQ-035 Counter wrap: with CNT_W=2, issue 5 loads -> done_cnt sequence 1,2,3,0,1.
